// File: rtl/blink_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode encoding and helpers.
package blink_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  typedef enum logic [1:0] {
    OFF   = MODE_OFF,
    ON    = MODE_ON,
    BLINK = MODE_BLINK,
    PULSE = MODE_PULSE
  } mode_t;

  // Only BLINK and PULSE run the half-period counter; OFF and ON are static levels.
  function automatic logic is_counting(input mode_t m);
    return (m == BLINK) || (m == PULSE);
  endfunction

endpackage

// File: rtl/blink_chan.sv
// One LED channel: holds its mode, half-period and counter, and drives a
// registered led bit plus a one-cycle tick each time the counter wraps.
module blink_chan
  import blink_pkg::*;
#(
  parameter int                CPT_W        = 26,
  parameter logic [CPT_W-1:0]  DEFAULT_HALF = CPT_W'(25_000_000),
  parameter mode_t             DEFAULT_MODE = BLINK
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic             sync,
  input  logic [1:0]       cfg_mode,
  input  logic [CPT_W-1:0] cfg_half,
  output logic             led,
  output logic             tick
);

  localparam logic [CPT_W-1:0] ONE = CPT_W'(1);

  mode_t            mode;
  mode_t            new_mode;
  logic [CPT_W-1:0] half;
  logic [CPT_W-1:0] cnt;
  logic [CPT_W-1:0] last;
  logic             counting;
  logic             wrap;

  // A half of zero is treated as one, so the terminal count is never below zero.
  assign last     = (half == '0) ? '0 : half - ONE;
  assign counting = is_counting(mode);
  assign wrap     = counting && (cnt == last);
  assign new_mode = mode_t'(cfg_mode);

  // Channel state: reset wins, then a config load, then a sync restart, then normal counting;
  // a wrap that lands on a load or sync cycle is dropped because those branches win.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mode <= DEFAULT_MODE;
      half <= DEFAULT_HALF;
      cnt  <= '0;
      led  <= (DEFAULT_MODE == ON);
      tick <= 1'b0;
    end else if (load) begin
      mode <= new_mode;
      half <= cfg_half;
      cnt  <= '0;
      led  <= (new_mode == ON);
      tick <= 1'b0;
    end else if (sync && counting) begin
      cnt  <= '0;
      led  <= 1'b0;
      tick <= 1'b0;
    end else begin
      case (mode)
        OFF: begin
          cnt  <= '0;
          led  <= 1'b0;
          tick <= 1'b0;
        end
        ON: begin
          cnt  <= '0;
          led  <= 1'b1;
          tick <= 1'b0;
        end
        BLINK: begin
          cnt  <= wrap ? '0 : cnt + ONE;
          led  <= led ^ wrap;
          tick <= wrap;
        end
        PULSE: begin
          cnt  <= wrap ? '0 : cnt + ONE;
          led  <= wrap;
          tick <= wrap;
        end
        default: begin
          cnt  <= '0;
          led  <= 1'b0;
          tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_blink.sv
// Bank of NCH independent LED blinkers sharing one configuration write port
// and one global phase-restart strobe.
module multi_blink
  import blink_pkg::*;
#(
  parameter int          NCH          = 4,
  parameter int          CPT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 25_000_000,
  parameter mode_t       DEFAULT_MODE = BLINK,
  localparam int         CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CPT_W-1:0] cfg_half,
  input  logic             sync_i,
  output logic [NCH-1:0]   led_o,
  output logic [NCH-1:0]   tick_o
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic load;

    // An address at or above NCH matches no channel, so such writes fall away here.
    assign load = cfg_we && (cfg_ch == CH_W'(i));

    blink_chan #(
      .CPT_W        (CPT_W),
      .DEFAULT_HALF (CPT_W'(DEFAULT_HALF)),
      .DEFAULT_MODE (DEFAULT_MODE)
    ) u_chan (
      .clk      (CLK),
      .n_rst    (NRST),
      .load     (load),
      .sync     (sync_i),
      .cfg_mode (cfg_mode),
      .cfg_half (cfg_half),
      .led      (led_o[i]),
      .tick     (tick_o[i])
    );
  end

endmodule
